digital_loop_filter: RTL

DIGITAL_LOOP_FILTER -- requirements
Module: digital_loop_filter

---
 rtl/digital_loop_filter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/digital_loop_filter.sv
// Digital PI loop filter: synchronizes bang-bang phase-detector UP/DOWN, integrates the
// decision with anti-windup, and produces a clamped oscillator control word plus lock status.
module digital_loop_filter #(
    parameter int CTRL_W     = 10,
    parameter int INT_W      = 16,
    parameter int FRAC       = 4,
    parameter int KP         = 4,
    parameter int KI         = 1,
    parameter int CENTER     = 512,
    parameter int LOCK_COUNT = 64
) (
    input  logic              input_reference_clock_digital,
    input  logic              reset,
    input  logic              input_up_digital,
    input  logic              input_down_digital,
    input  logic              input_hold_digital,
    output logic [CTRL_W-1:0] output_control_word_digital,
    output logic              output_locked_digital,
    output logic              output_saturated_digital
);

    // Wide enough that CENTER + shifted integrator + proportional term never wraps.
    localparam int UW    = INT_W + CTRL_W + 8;
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    typedef logic signed [UW-1:0] wide_t;

    localparam wide_t W_INT_MAX = wide_t'((64'sd1 <<< (INT_W - 1)) - 64'sd1);
    localparam wide_t W_INT_MIN = -W_INT_MAX;
    localparam wide_t W_OUT_MAX = wide_t'((64'sd1 <<< CTRL_W) - 64'sd1);
    localparam wide_t W_CENTER  = wide_t'(CENTER);
    localparam wide_t W_KP      = wide_t'(KP);
    localparam wide_t W_KI      = wide_t'(KI);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_COUNT);

    logic                     r_up_meta, r_up_sync, r_dn_meta, r_dn_sync;
    logic signed [INT_W-1:0]  r_integ;
    logic signed [1:0]        r_prev_d;
    logic [CNT_W-1:0]         r_lock_cnt;
    logic [CTRL_W-1:0]        r_ctrl;
    logic                     r_locked;
    logic                     r_sat;

    logic signed [1:0]        w_d;
    wide_t                    w_integ_w, w_p_term, w_i_step, w_u_pre, w_integ_try;
    wide_t                    w_integ_next_w, w_u;
    logic                     w_windup;
    logic [CTRL_W-1:0]        w_ctrl_next;
    logic                     w_sat_next;
    logic signed [1:0]        w_prev_next;
    logic [CNT_W-1:0]         w_cnt_next, w_cnt_inc;

    // Two-flop synchronizers for the asynchronous phase-detector inputs.
    always_ff @(posedge input_reference_clock_digital or posedge reset) begin
        if (reset) begin
            r_up_meta <= 1'b0;
            r_up_sync <= 1'b0;
            r_dn_meta <= 1'b0;
            r_dn_sync <= 1'b0;
        end else begin
            r_up_meta <= input_up_digital;
            r_up_sync <= r_up_meta;
            r_dn_meta <= input_down_digital;
            r_dn_sync <= r_dn_meta;
        end
    end

    // Decision, proportional/integral terms and anti-windup integrator update.
    always_comb begin
        w_d            = 2'sb00;
        w_p_term       = '0;
        w_i_step       = '0;
        w_integ_w      = {{(UW-INT_W){r_integ[INT_W-1]}}, r_integ};
        w_integ_try    = '0;
        w_integ_next_w = w_integ_w;
        w_windup       = 1'b0;
        w_u_pre        = '0;
        w_u            = '0;
        case ({r_up_sync, r_dn_sync})
            2'b10:   w_d = 2'sb01;
            2'b01:   w_d = 2'sb11;
            default: w_d = 2'sb00;
        endcase
        case (w_d)
            2'sb01: begin
                w_p_term = W_KP;
                w_i_step = W_KI;
            end
            2'sb11: begin
                w_p_term = -W_KP;
                w_i_step = -W_KI;
            end
            default: begin
                w_p_term = '0;
                w_i_step = '0;
            end
        endcase
        // Windup is judged on the control word the current integrator already demands.
        w_u_pre  = W_CENTER + (w_integ_w >>> FRAC) + w_p_term;
        w_windup = ((w_d == 2'sb01) && (w_u_pre > W_OUT_MAX)) ||
                   ((w_d == 2'sb11) && w_u_pre[UW-1]);
        w_integ_try = w_integ_w + w_i_step;
        if (w_integ_try > W_INT_MAX) begin
            w_integ_try = W_INT_MAX;
        end else if (w_integ_try < W_INT_MIN) begin
            w_integ_try = W_INT_MIN;
        end else begin
            w_integ_try = w_integ_try;
        end
        if (input_hold_digital || w_windup) begin
            w_integ_next_w = w_integ_w;
        end else begin
            w_integ_next_w = w_integ_try;
        end
        w_u = W_CENTER + (w_integ_next_w >>> FRAC) + w_p_term;
    end

    // Clamp the unclamped control word into the oscillator range.
    always_comb begin
        w_ctrl_next = '0;
        w_sat_next  = 1'b0;
        if (w_u > W_OUT_MAX) begin
            w_ctrl_next = '1;
            w_sat_next  = 1'b1;
        end else if (w_u[UW-1]) begin
            w_ctrl_next = '0;
            w_sat_next  = 1'b1;
        end else begin
            w_ctrl_next = w_u[CTRL_W-1:0];
            w_sat_next  = 1'b0;
        end
    end

    // Lock qualification: a repeated nonzero decision means the loop is still slewing.
    always_comb begin
        w_cnt_inc   = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_cnt_next  = r_lock_cnt;
        w_prev_next = r_prev_d;
        if (input_hold_digital) begin
            w_cnt_next  = r_lock_cnt;
            w_prev_next = r_prev_d;
        end else if (w_d == 2'sb00) begin
            w_cnt_next  = w_cnt_inc;
            w_prev_next = r_prev_d;
        end else if (w_d == r_prev_d) begin
            w_cnt_next  = {CNT_W{1'b0}};
            w_prev_next = w_d;
        end else begin
            w_cnt_next  = w_cnt_inc;
            w_prev_next = w_d;
        end
    end

    // Loop-filter state and registered outputs.
    always_ff @(posedge input_reference_clock_digital or posedge reset) begin
        if (reset) begin
            r_integ    <= '0;
            r_prev_d   <= 2'sb00;
            r_lock_cnt <= {CNT_W{1'b0}};
            r_ctrl     <= CTRL_W'(CENTER);
            r_locked   <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_integ    <= w_integ_next_w[INT_W-1:0];
            r_prev_d   <= w_prev_next;
            r_lock_cnt <= w_cnt_next;
            r_ctrl     <= w_ctrl_next;
            r_locked   <= (w_cnt_next == LOCK_MAX);
            r_sat      <= w_sat_next;
        end
    end

    assign output_control_word_digital = r_ctrl;
    assign output_locked_digital       = r_locked;
    assign output_saturated_digital    = r_sat;

endmodule
